bch_chien_serial: RTL and testbench

Serial Chien search stage for the BCH decoder; sits directly downstream of the key-equation solver. Takes the error-locator polynomial sigma and the solver's predicted error count. Evaluates sigma at one codeword position per beat and streams a per-position error flag to the corrector, with valid/ready backpressure. Optionally checks that the number of roots found matches the predicted count and flags an uncorrectable word.

---
 rtl/bch_chien_serial.sv | 136 +++++++++++++
 tb/tb_bch_chien_serial.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/bch_chien_serial.sv
// Serial Chien search: evaluates the error locator at one codeword position per beat.
// Define BCH_CHIEN_ROOTCHECK_EN to build the root counter and the uncorrectable-word flag.
module bch_chien_serial #(
    parameter int          M    = 4,
    parameter int          T    = 2,
    parameter int          N    = 15,
    parameter logic [M:0]  POLY = 5'b10011,
    localparam int         EW   = $clog2(T + 1)
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_start,
    input  logic [(T+1)*M-1:0]   i_sigma,
    input  logic [EW-1:0]        i_err_count,
    output logic                 o_busy,
    output logic                 o_out_valid,
    input  logic                 i_out_ready,
    output logic                 o_err_out,
    output logic                 o_out_last,
    output logic                 o_fail
);
    localparam int RW = $clog2(T + 2);
    localparam int JW = (N > 1) ? $clog2(N) : 1;
    localparam int Q  = (1 << M) - 1;

    typedef enum logic {IDLE, RUN} state_t;

    function automatic logic [M-1:0] gf_mulx(input logic [M-1:0] x);
        logic [M:0] t;
        t = {x, 1'b0};
        if (t[M]) t = t ^ POLY;
        return t[M-1:0];
    endfunction

    // k is always a per-coefficient constant, so this folds into an XOR network.
    function automatic logic [M-1:0] gf_mul_apow(input logic [M-1:0] x, input int k);
        logic [M-1:0] y;
        y = x;
        for (int n = 0; n < (k % Q); n++) y = gf_mulx(y);
        return y;
    endfunction

    state_t                  r_state, w_state_next;
    logic [T:0][M-1:0]       r_coef, w_coef_load, w_coef_step, w_coef_next;
    logic [JW-1:0]           r_j, w_j_next;
    logic                    r_err_out, r_last, r_fail;
    logic                    w_load, w_hs, w_fin;
    logic                    w_err_next, w_last_next, w_fail_next;
    logic [M-1:0]            w_sum;

    for (genvar i = 0; i <= T; i++) begin : g_coef
        assign w_coef_load[i] = gf_mul_apow(i_sigma[i*M +: M], i * (Q + 1 - N));
        assign w_coef_step[i] = gf_mul_apow(r_coef[i], i);
    end

    always_comb begin
        w_load       = (r_state == IDLE) && i_start;
        w_hs         = (r_state == RUN) && i_out_ready;
        w_fin        = w_hs && (r_j == JW'(N - 1));
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (i_start) w_state_next = RUN;
            RUN:     if (w_fin)   w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) r_state <= IDLE;
        else         r_state <= w_state_next;
    end

    // Outputs are registered from the next-beat values, so nothing depends on i_out_ready combinationally.
    always_comb begin
        w_coef_next = w_load ? w_coef_load : w_coef_step;
        w_j_next    = w_load ? '0 : r_j + JW'(1);
        w_sum       = '0;
        for (int i = 0; i <= T; i++) w_sum = w_sum ^ w_coef_next[i];
        w_err_next  = (w_sum == '0);
        w_last_next = (w_j_next == JW'(N - 1));
    end

`ifdef BCH_CHIEN_ROOTCHECK_EN
    logic [RW-1:0] r_roots, w_roots_next;
    logic [EW-1:0] r_ec, w_ec_next;

    always_comb begin
        w_ec_next = w_load ? i_err_count : r_ec;
        if (w_load)                            w_roots_next = '0;
        else if (r_err_out && (r_roots != '1)) w_roots_next = r_roots + RW'(1);
        else                                   w_roots_next = r_roots;
        w_fail_next = w_last_next &&
                      (({1'b0, w_roots_next} + (RW+1)'(w_err_next)) != (RW+1)'(w_ec_next));
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_roots <= '0;
            r_ec    <= '0;
        end else if (w_load || (w_hs && !w_fin)) begin
            r_roots <= w_roots_next;
            r_ec    <= w_ec_next;
        end
    end
`else
    logic w_unused_ec;
    assign w_unused_ec = ^i_err_count;
    assign w_fail_next = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_coef    <= '0;
            r_j       <= '0;
            r_err_out <= 1'b0;
            r_last    <= 1'b0;
            r_fail    <= 1'b0;
        end else if (w_load || (w_hs && !w_fin)) begin
            r_coef    <= w_coef_next;
            r_j       <= w_j_next;
            r_err_out <= w_err_next;
            r_last    <= w_last_next;
            r_fail    <= w_fail_next;
        end else if (w_fin) begin
            r_err_out <= 1'b0;
            r_last    <= 1'b0;
            r_fail    <= 1'b0;
        end
    end

    assign o_busy      = (r_state == RUN);
    assign o_out_valid = (r_state == RUN);
    assign o_err_out   = r_err_out;
    assign o_out_last  = r_last;
    assign o_fail      = r_fail;
endmodule

// File: tb/tb_bch_chien_serial.sv
// Scoreboard bench for bch_chien_serial: a GF(16) reference evaluates sigma per position.
module tb_bch_chien_serial;
    localparam int         M    = 4;
    localparam int         T    = 2;
    localparam int         N    = 15;
    localparam logic [M:0] POLY = 5'b10011;
    localparam int         EW   = $clog2(T + 1);
    localparam int         RW   = $clog2(T + 2);
    localparam int         SW   = (T + 1) * M;
`ifdef BCH_CHIEN_ROOTCHECK_EN
    localparam bit RC = 1'b1;
`else
    localparam bit RC = 1'b0;
`endif

    logic          clk;
    logic          i_reset, i_start, i_out_ready;
    logic [SW-1:0] i_sigma;
    logic [EW-1:0] i_err_count;
    logic          o_busy, o_out_valid, o_err_out, o_out_last, o_fail;

    bch_chien_serial #(.M(M), .T(T), .N(N), .POLY(POLY)) dut (
        .i_clk(clk), .i_reset(i_reset), .i_start(i_start), .i_sigma(i_sigma),
        .i_err_count(i_err_count), .o_busy(o_busy), .o_out_valid(o_out_valid),
        .i_out_ready(i_out_ready), .o_err_out(o_err_out), .o_out_last(o_out_last),
        .o_fail(o_fail)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic err;
        logic last;
        logic fail;
    } beat_t;

    beat_t exp_q[$];
    int    checks   = 0;
    int    failures = 0;

    function automatic logic [M-1:0] gf_mulx(input logic [M-1:0] x);
        logic [M:0] t;
        t = {x, 1'b0};
        if (t[M]) t = t ^ POLY;
        return t[M-1:0];
    endfunction

    function automatic logic [M-1:0] gf_mul(input logic [M-1:0] a, input logic [M-1:0] b);
        logic [M-1:0] r;
        r = '0;
        for (int k = M - 1; k >= 0; k--) begin
            r = gf_mulx(r);
            if (b[k]) r = r ^ a;
        end
        return r;
    endfunction

    function automatic logic [M-1:0] gf_apow(input int e);
        logic [M-1:0] x;
        x = 1;
        for (int k = 0; k < e; k++) x = gf_mulx(x);
        return x;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected stream for one word: err_out at position j is sigma(alpha^(j+2^M-N)) == 0.
    task automatic push_word(input logic [SW-1:0] sig, input int ec);
        logic [M-1:0] x, v;
        int           roots;
        beat_t        b;
        x     = gf_apow((1 << M) - N);
        roots = 0;
        for (int j = 0; j < N; j++) begin
            v = '0;
            for (int i = T; i >= 0; i--) v = gf_mul(v, x) ^ sig[i*M +: M];
            b.err  = (v == '0);
            b.last = (j == N - 1);
            b.fail = RC && b.last && ((roots + int'(b.err)) != ec);
            exp_q.push_back(b);
            if (b.err && roots != (1 << RW) - 1) roots++;
            x = gf_mulx(x);
        end
    endtask

    task automatic start_word(input logic [SW-1:0] sig, input int ec);
        push_word(sig, ec);
        i_sigma     = sig;
        i_err_count = EW'(ec);
        i_start     = 1'b1;
        @(negedge clk);
        i_start     = 1'b0;
        chk("busy_after_start", o_busy, 1);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_busy"},  o_busy, 0);
        chk({tag, "_valid"}, o_out_valid, 0);
        chk({tag, "_err"},   o_err_out, 0);
        chk({tag, "_last"},  o_out_last, 0);
        chk({tag, "_fail"},  o_fail, 0);
    endtask

    // Consume the word: optional stall on one beat, start pokes on two beats, reset abort on one beat.
    task automatic drain(input int stall_beat, input int stall_n, input int pa, input int pb,
                         input int abort_beat);
        int  beat, cyc, stalls, cur;
        bit  hs;
        beat   = 0;
        cyc    = 0;
        stalls = 0;
        while (exp_q.size() > 0 && cyc < 100) begin
            if (beat == abort_beat) begin
                i_reset = 1'b1;
                @(negedge clk);
                i_reset = 1'b0;
                chk_idle("abort");
                exp_q.delete();
                return;
            end
            chk("run_busy", o_busy, 1);
            chk("run_valid", o_out_valid, 1);
            hs = !(beat == stall_beat && stalls < stall_n);
            if (!hs) stalls++;
            i_out_ready = hs;
            chk($sformatf("err_b%0d", beat),  o_err_out,  exp_q[0].err);
            chk($sformatf("last_b%0d", beat), o_out_last, exp_q[0].last);
            chk($sformatf("fail_b%0d", beat), o_fail,     exp_q[0].fail);
            cur = beat;
            if (hs) begin
                void'(exp_q.pop_front());
                beat++;
            end
            i_start = (cur == pa || cur == pb);
            if (i_start) begin
                i_sigma     = 12'h5A3;
                i_err_count = 2'd2;
            end
            @(negedge clk);
            cyc++;
        end
        i_start     = 1'b0;
        i_out_ready = 1'b1;
        chk("beats_left", exp_q.size(), 0);
        chk("word_cycles", cyc, N + stall_n);
        chk("end_busy", o_busy, 0);
        chk("end_valid", o_out_valid, 0);
        exp_q.delete();
    endtask

    initial begin
        logic [SW-1:0] s;
        logic [M-1:0]  r1, r2;
        i_reset     = 1'b1;
        i_start     = 1'b0;
        i_out_ready = 1'b1;
        i_sigma     = '0;
        i_err_count = '0;
        repeat (2) @(negedge clk);
        chk_idle("reset");
        i_reset = 1'b0;
        @(negedge clk);
        chk_idle("post_reset");

        // No errors, single error with matching and mismatching counts.
        start_word(12'h001, 0);
        drain(-1, 0, -1, -1, -1);
        start_word(12'h071, 1);
        drain(-1, 0, -1, -1, -1);
        start_word(12'h071, 2);
        drain(-1, 0, -1, -1, -1);

        // Backpressure on beat 4 for three cycles.
        start_word(12'h071, 1);
        drain(4, 3, -1, -1, -1);

        // start pulsed mid-word and on the final handshake is ignored.
        start_word(12'h071, 1);
        drain(-1, 0, 3, 14, -1);

        // Reset mid-word, then a clean word.
        start_word(12'h071, 1);
        drain(-1, 0, -1, -1, 7);
        start_word(12'h071, 1);
        drain(-1, 0, -1, -1, -1);

        // Degenerate all-zero locator.
        start_word(12'h000, 0);
        drain(-1, 0, -1, -1, -1);

        // Two-root locator (1 + a^3 x)(1 + a^9 x), stall on the first root.
        r1 = gf_apow(3);
        r2 = gf_apow(9);
        s  = {gf_mul(r1, r2), r1 ^ r2, 4'h1};
        start_word(s, 2);
        drain(11, 2, -1, -1, -1);
        start_word(s, 1);
        drain(-1, 0, -1, -1, -1);

        // A few arbitrary locators.
        for (int k = 0; k < 3; k++) begin
            s = SW'($urandom);
            start_word(s, int'($urandom_range(0, T)));
            drain(int'($urandom_range(0, N - 1)), 1, -1, -1, -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
